// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative restoring integer divider, functional-unit slot 2 (div)
//
// Retires BITS_PER_CYCLE quotient bits per CALC cycle on unsigned magnitudes,
// then applies the latched signs in FIXUP.  The finished result is held in
// DONE and the unit requests the CDB until it is granted.
//
// Ports
//   clk        rising-edge clock
//   nRST       asynchronous active-low reset
//   EN         issue strobe from the reservation station (honoured only when idle)
//   op         00 signed quot, 01 signed rem, 10 unsigned quot, 11 unsigned rem
//   dataIn1    dividend
//   dataIn2    divisor
//   labelIn    tag of the issuing RS entry
//   available  unit idle, may accept EN
//   require    result valid, requesting the CDB
//   requireAC  CDB grant
//   result     quotient or remainder (0 unless require)
//   labelOut   tag broadcast with result (0 unless require)
//   busy       state != IDLE
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH          = 32,
    parameter int LABEL_W        = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               EN,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   dataIn1,
    input  logic [WIDTH-1:0]   dataIn2,
    input  logic [LABEL_W-1:0] labelIn,
    output logic               available,
    output logic               require,
    input  logic               requireAC,
    output logic [WIDTH-1:0]   result,
    output logic [LABEL_W-1:0] labelOut,
    output logic               busy
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   quo;        // dividend shifts out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0]   rem;        // partial remainder, always < divisor
    logic [WIDTH-1:0]   dvsr;
    logic               negQ, negR, opRem;
    logic [CNT_W-1:0]   count;
    logic [LABEL_W-1:0] labelReg;

    // Operand magnitudes; signed ops only.  -0x80..0 wraps to 0x80..0, which is
    // the correct unsigned magnitude 2^(WIDTH-1).
    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;

    assign sign1 = ~op[1] & dataIn1[WIDTH-1];
    assign sign2 = ~op[1] & dataIn2[WIDTH-1];
    assign mag1  = sign1 ? -dataIn1 : dataIn1;
    assign mag2  = sign2 ? -dataIn2 : dataIn2;

    // One CALC cycle of restoring division, unrolled BITS_PER_CYCLE times.
    // The trial value needs WIDTH+1 bits: 2*rem+1 can exceed 2^WIDTH-1.
    logic [WIDTH-1:0] qNext, rNext;
    logic [WIDTH:0]   trial, diff;

    always_comb begin
        qNext = quo;
        rNext = rem;
        trial = '0;
        diff  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial = {rNext, qNext[WIDTH-1]};
            diff  = trial - {1'b0, dvsr};
            // diff MSB set means trial < divisor: restore (keep trial)
            rNext = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            qNext = {qNext[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    assign available = (state == IDLE);
    assign require   = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            opRem    <= 1'b0;
            count    <= '0;
            labelReg <= '0;
            result   <= '0;
            labelOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EN) begin
                        opRem    <= op[0];
                        labelReg <= labelIn;
                        negQ     <= sign1 ^ sign2;
                        negR     <= sign1;
                        quo      <= mag1;
                        dvsr     <= mag2;
                        rem      <= '0;
                        count    <= '0;
                        if (dataIn2 == '0) begin
                            // Divide by zero skips the datapath entirely.
                            result   <= op[0] ? dataIn1 : '1;
                            labelOut <= labelIn;
                            state    <= DONE;
                        end else begin
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo   <= qNext;
                    rem   <= rNext;
                    count <= count + 1'b1;
                    if (count == LAST) state <= FIXUP;
                end
                FIXUP: begin
                    if (opRem) result <= negR ? -rem : rem;
                    else       result <= negQ ? -quo : quo;
                    labelOut <= labelReg;
                    state    <= DONE;
                end
                DONE: begin
                    if (requireAC) begin
                        // Clear so the CDB mux sees an empty tag once released.
                        result   <= '0;
                        labelOut <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        nRST;
    logic        EN;
    logic [1:0]  op;
    logic [31:0] dataIn1, dataIn2;
    logic [3:0]  labelIn;
    logic        available, require, requireAC, busy;
    logic [31:0] result;
    logic [3:0]  labelOut;

    int passCnt  = 0;
    int totalCnt = 0;
    int lat;
    int reqSeen;

    div_unit #(.WIDTH(32), .LABEL_W(4), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .nRST(nRST), .EN(EN), .op(op),
        .dataIn1(dataIn1), .dataIn2(dataIn2), .labelIn(labelIn),
        .available(available), .require(require), .requireAC(requireAC),
        .result(result), .labelOut(labelOut), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Present an op for exactly one rising edge (E0).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] lbl);
        @(negedge clk);
        EN = 1'b1; op = o; dataIn1 = a; dataIn2 = b; labelIn = lbl;
        @(posedge clk);
        #1 EN = 1'b0;
        dataIn1 = 32'hDEADBEEF; dataIn2 = 32'h0BADF00D;   // post-capture changes must be ignored
    endtask

    // Edges after E0 until require is seen; 100 means it never came.
    task automatic waitReq(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1 n++;
            if (require) break;
        end
    endtask

    task automatic grant();
        @(negedge clk);
        requireAC = 1'b1;
        @(posedge clk);
        #1 requireAC = 1'b0;
        chk("avail after grant", {31'b0, available}, 32'd1);
        chk("req after grant",   {31'b0, require},   32'd0);
        chk("label after grant", {28'b0, labelOut},  32'd0);
        chk("result after grant", result,            32'd0);
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] lbl,
                         input int expLat, input logic [31:0] expRes);
        int n;
        issue(o, a, b, lbl);
        waitReq(n);
        chk({tag, " latency"}, n, expLat);
        chk({tag, " result"}, result, expRes);
        chk({tag, " label"}, {28'b0, labelOut}, {28'b0, lbl});
        grant();
    endtask

    initial begin
        nRST = 1'b0; EN = 1'b0; op = 2'b00; dataIn1 = '0; dataIn2 = '0;
        labelIn = '0; requireAC = 1'b0;
        #12;
        chk("rst available", {31'b0, available}, 32'd1);
        chk("rst require",   {31'b0, require},   32'd0);
        chk("rst busy",      {31'b0, busy},      32'd0);
        chk("rst result",    result,             32'd0);
        chk("rst label",     {28'b0, labelOut},  32'd0);
        @(negedge clk) nRST = 1'b1;

        // 1: basic signed quotient, full latency
        runOp("sq 100/7",   2'b00, 32'd100, 32'd7, 4'd5, 33, 32'd14);
        // 2: sign handling and unsigned ops
        runOp("sr -100%7",  2'b01, 32'hFFFFFF9C, 32'd7, 4'd1, 33, 32'hFFFFFFFE);
        runOp("sq -100/7",  2'b00, 32'hFFFFFF9C, 32'd7, 4'd2, 33, 32'hFFFFFFF2);
        runOp("uq ~0/2",    2'b10, 32'hFFFFFFFF, 32'd2, 4'd3, 33, 32'h7FFFFFFF);
        runOp("uq ~0/10",   2'b10, 32'hFFFFFFFF, 32'd10, 4'd4, 33, 32'h19999999);
        runOp("ur ~0%10",   2'b11, 32'hFFFFFFFF, 32'd10, 4'd6, 33, 32'd5);
        runOp("sq 7/-100",  2'b00, 32'd7, 32'hFFFFFF9C, 4'd7, 33, 32'd0);
        runOp("sr 7%-100",  2'b01, 32'd7, 32'hFFFFFF9C, 4'd8, 33, 32'd7);
        // 3: divide by zero
        runOp("dz quot",    2'b00, 32'h1234, 32'd0, 4'd9, 1, 32'hFFFFFFFF);
        runOp("dz rem",     2'b01, 32'h1234, 32'd0, 4'd10, 1, 32'h1234);
        runOp("dz urem",    2'b11, 32'h80000001, 32'd0, 4'd11, 1, 32'h80000001);
        // 4: signed overflow wraps
        runOp("ovf quot",   2'b00, 32'h80000000, 32'hFFFFFFFF, 4'd12, 33, 32'h80000000);
        runOp("ovf rem",    2'b01, 32'h80000000, 32'hFFFFFFFF, 4'd13, 33, 32'd0);
        runOp("umax/umax",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, 33, 32'd1);

        // 5: hold in DONE without grant; EN must be ignored
        issue(2'b00, 32'd100, 32'd7, 4'd3);
        waitReq(lat);
        chk("hold latency", lat, 33);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            EN = 1'b1; op = 2'b10; dataIn1 = 32'd50; dataIn2 = 32'd5; labelIn = 4'd9;
            @(posedge clk);
            #1;
            chk("hold result", result, 32'd14);
            chk("hold label",  {28'b0, labelOut}, 32'd3);
            chk("hold req",    {31'b0, require},  32'd1);
        end
        EN = 1'b0;
        grant();
        runOp("after hold", 2'b10, 32'd50, 32'd5, 4'd9, 33, 32'd10);

        // 6: async reset mid-CALC (count 10)
        issue(2'b00, 32'd100, 32'd7, 4'd15);
        repeat (10) @(posedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("abort available", {31'b0, available}, 32'd1);
        chk("abort require",   {31'b0, require},   32'd0);
        chk("abort busy",      {31'b0, busy},      32'd0);
        chk("abort result",    result,             32'd0);
        chk("abort label",     {28'b0, labelOut},  32'd0);
        @(negedge clk) nRST = 1'b1;
        reqSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (require) reqSeen++;
        end
        chk("abort no req", reqSeen, 0);
        runOp("post reset", 2'b01, 32'd100, 32'd7, 4'd2, 33, 32'd2);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
